fe_pc_ctrl: RTL and testbench

Fetch-side PC controller. It is the receiving end of the writeback→fetch redirect interface: it consumes target address, PC_MUX, branch-stall release and trap-stall release. It holds and advances the fetch PC, squashes fetch while a control-flow or SYSTEM instruction is in flight, and loads the redirect or trap target. It also generates the fetch instruction-address-misaligned flag (FE_IAM) that feeds the trap handler at writeback.

---
 rtl/fe_pc_ctrl.sv | 164 ++++++++++++++++
 tb/tb_fe_pc_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fe_pc_ctrl.sv
// Fetch-side PC controller: holds and advances the fetch PC, squashes fetch while
// a control-flow or SYSTEM instruction is in flight, and applies writeback
// redirects and trap targets. It also raises the fetch misaligned-target flag
// (FE_IAM) for the trap handler.
// Optional build macro: FE_PERF_CNT_EN adds a saturating stall-cycle counter
// output (FE_STALL_CNT).
module fe_pc_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        ICACHE_R,
    input  logic        DE_STALL,
    input  logic        DE_FE_CF,
    input  logic        DE_FE_SYS,
    input  logic [63:0] WB_FE_Target_Address,
    input  logic        WB_FE_PC_MUX,
    input  logic        WB_FE_BR_STALL,
    input  logic        WB_FE_TRAP_STALL,
    input  logic        TRAP_CS,
    input  logic [63:0] TRAP_Target,
    output logic [63:0] FE_PC,
    output logic        FE_ICACHE_REQ,
    output logic        FE_V,
    output logic        FE_IAM,
`ifdef FE_PERF_CNT_EN
    output logic [31:0] FE_STALL_CNT,
`endif
    output logic [1:0]  FE_STATE
);

    localparam int unsigned PC_W  = 64;
    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_BR_WAIT   = 2'd1,
        ST_TRAP_WAIT = 2'd2,
        ST_IAM_WAIT  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   pc_seq;
    logic              req_q, req_d;
    logic              v_q, v_d;
    logic              iam_q, iam_d;
    logic              tgt_aligned;

    assign pc_seq      = pc_q + PC_W'(PC_STEP);
    assign tgt_aligned = (WB_FE_Target_Address[1:0] == 2'b00);

    // Next-state, next-PC and next-output decode (trap > writeback > decode > advance)
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        v_d     = 1'b0;
        iam_d   = 1'b0;

        if (TRAP_CS) begin
            pc_d    = TRAP_Target;
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (WB_FE_PC_MUX) begin
                        // A redirect from writeback kills the decode entry on the wrong path
                        if (tgt_aligned) begin
                            pc_d = WB_FE_Target_Address;
                        end else begin
                            iam_d   = 1'b1;
                            state_d = ST_IAM_WAIT;
                        end
                    end else begin
                        if (ICACHE_R && !DE_STALL) begin
                            pc_d = pc_seq;
                        end
                        if (DE_FE_SYS) begin
                            state_d = ST_TRAP_WAIT;
                        end else if (DE_FE_CF) begin
                            state_d = ST_BR_WAIT;
                        end
                        // Word fetched alongside a CF/SYS entry is on a speculative path
                        v_d = ICACHE_R && !DE_FE_SYS && !DE_FE_CF;
                    end
                end
                ST_BR_WAIT: begin
                    if (WB_FE_BR_STALL) begin
                        if (!WB_FE_PC_MUX) begin
                            state_d = ST_RUN;
                        end else if (tgt_aligned) begin
                            pc_d    = WB_FE_Target_Address;
                            state_d = ST_RUN;
                        end else begin
                            iam_d   = 1'b1;
                            state_d = ST_IAM_WAIT;
                        end
                    end
                end
                ST_TRAP_WAIT: begin
                    if (WB_FE_TRAP_STALL) begin
                        state_d = ST_RUN;
                    end
                end
                ST_IAM_WAIT: begin
                    state_d = ST_IAM_WAIT;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end

        req_d = (state_d == ST_RUN);
    end

    // State, PC and output registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            v_q     <= 1'b0;
            iam_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            v_q     <= v_d;
            iam_q   <= iam_d;
        end
    end

    assign FE_PC         = pc_q;
    assign FE_ICACHE_REQ = req_q;
    assign FE_V          = v_q;
    assign FE_IAM        = iam_q;
    assign FE_STATE      = state_q;

`ifdef FE_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count of cycles spent outside RUN
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q != ST_RUN) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register, cleared only by reset
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign FE_STALL_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_fe_pc_ctrl.sv
// Directed bench for fe_pc_ctrl: expected outputs are queued per step and
// compared against the DUT one clock later.
module tb_fe_pc_ctrl;

    logic        CLK;
    logic        RESET_N;
    logic        ICACHE_R;
    logic        DE_STALL;
    logic        DE_FE_CF;
    logic        DE_FE_SYS;
    logic [63:0] WB_FE_Target_Address;
    logic        WB_FE_PC_MUX;
    logic        WB_FE_BR_STALL;
    logic        WB_FE_TRAP_STALL;
    logic        TRAP_CS;
    logic [63:0] TRAP_Target;
    logic [63:0] FE_PC;
    logic        FE_ICACHE_REQ;
    logic        FE_V;
    logic        FE_IAM;
    logic [1:0]  FE_STATE;
`ifdef FE_PERF_CNT_EN
    logic [31:0] FE_STALL_CNT;
`endif

    typedef struct {
        string       tag;
        logic [63:0] pc;
        logic [1:0]  st;
        logic        v;
        logic        req;
        logic        iam;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    fe_pc_ctrl #(
        .RESET_PC (64'h0),
        .PC_STEP  (4)
    ) dut (
        .CLK                  (CLK),
        .RESET_N              (RESET_N),
        .ICACHE_R             (ICACHE_R),
        .DE_STALL             (DE_STALL),
        .DE_FE_CF             (DE_FE_CF),
        .DE_FE_SYS            (DE_FE_SYS),
        .WB_FE_Target_Address (WB_FE_Target_Address),
        .WB_FE_PC_MUX         (WB_FE_PC_MUX),
        .WB_FE_BR_STALL       (WB_FE_BR_STALL),
        .WB_FE_TRAP_STALL     (WB_FE_TRAP_STALL),
        .TRAP_CS              (TRAP_CS),
        .TRAP_Target          (TRAP_Target),
        .FE_PC                (FE_PC),
        .FE_ICACHE_REQ        (FE_ICACHE_REQ),
        .FE_V                 (FE_V),
        .FE_IAM               (FE_IAM),
`ifdef FE_PERF_CNT_EN
        .FE_STALL_CNT         (FE_STALL_CNT),
`endif
        .FE_STATE             (FE_STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard bound on run length
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input string field,
                       input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp_v);
        end
    endtask

    task automatic idle();
        ICACHE_R             = 1'b0;
        DE_STALL             = 1'b0;
        DE_FE_CF             = 1'b0;
        DE_FE_SYS            = 1'b0;
        WB_FE_Target_Address = 64'h0;
        WB_FE_PC_MUX         = 1'b0;
        WB_FE_BR_STALL       = 1'b0;
        WB_FE_TRAP_STALL     = 1'b0;
        TRAP_CS              = 1'b0;
        TRAP_Target          = 64'h0;
    endtask

    task automatic push_exp(input string tag, input logic [63:0] pc, input logic [1:0] st,
                            input logic v, input logic req, input logic iam);
        exp_t e;
        e.tag = tag; e.pc = pc; e.st = st; e.v = v; e.req = req; e.iam = iam;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        n_assert++;
        assert (sb_q.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk(e.tag, "pc",    FE_PC,                   e.pc);
            chk(e.tag, "state", 64'(FE_STATE),           64'(e.st));
            chk(e.tag, "v",     64'(FE_V),               64'(e.v));
            chk(e.tag, "req",   64'(FE_ICACHE_REQ),      64'(e.req));
            chk(e.tag, "iam",   64'(FE_IAM),             64'(e.iam));
        end
    endtask

    // Queue the expectation, clock once, then compare just after the edge
    task automatic step(input string tag, input logic [63:0] pc, input logic [1:0] st,
                        input logic v, input logic req, input logic iam);
        push_exp(tag, pc, st, v, req, iam);
        @(posedge CLK);
        #1;
        pop_check();
    endtask

    // Compare without a clock edge (asynchronous reset effects)
    task automatic check_now(input string tag, input logic [63:0] pc, input logic [1:0] st,
                             input logic v, input logic req, input logic iam);
        push_exp(tag, pc, st, v, req, iam);
        pop_check();
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] exp_cnt);
`ifdef FE_PERF_CNT_EN
        chk(tag, "stall_cnt", 64'(FE_STALL_CNT), 64'(exp_cnt));
`else
        if (tag.len() < 0) $display("%0d", exp_cnt);
`endif
    endtask

    initial begin
        idle();
        RESET_N = 1'b1;

        // Asynchronous reset asserted mid-cycle, before any clock edge
        #2 RESET_N = 1'b0;
        #1 check_now("rst_async", 64'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk_cnt("rst_async", 32'd0);
        step("rst_hold0", 64'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        step("rst_hold1", 64'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        RESET_N = 1'b1;

        // Sequential fetch
        ICACHE_R = 1'b1;
        step("seq0", 64'h4,  2'd0, 1'b1, 1'b1, 1'b0);
        step("seq1", 64'h8,  2'd0, 1'b1, 1'b1, 1'b0);
        step("seq2", 64'hC,  2'd0, 1'b1, 1'b1, 1'b0);
        step("seq3", 64'h10, 2'd0, 1'b1, 1'b1, 1'b0);

        // Taken branch at 0x10, released three cycles later to 0x40
        DE_FE_CF = 1'b1;
        step("cf_enter", 64'h14, 2'd1, 1'b0, 1'b0, 1'b0);
        DE_FE_CF = 1'b0;
        step("br_wait0", 64'h14, 2'd1, 1'b0, 1'b0, 1'b0);
        step("br_wait1", 64'h14, 2'd1, 1'b0, 1'b0, 1'b0);
        idle();
        WB_FE_BR_STALL = 1'b1; WB_FE_PC_MUX = 1'b1; WB_FE_Target_Address = 64'h40;
        step("br_taken", 64'h40, 2'd0, 1'b0, 1'b1, 1'b0);
        idle();
        ICACHE_R = 1'b1;
        step("after_taken", 64'h44, 2'd0, 1'b1, 1'b1, 1'b0);

        // Reset while waiting on a branch
        DE_FE_CF = 1'b1;
        step("cf2", 64'h48, 2'd1, 1'b0, 1'b0, 1'b0);
        idle();
        RESET_N = 1'b0;
        #1 check_now("rst_mid_wait", 64'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk_cnt("rst_mid_wait", 32'd0);
        step("rst_hold2", 64'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        RESET_N = 1'b1;

        // Not-taken branch at 0x10
        ICACHE_R = 1'b1;
        step("adv0", 64'h4,  2'd0, 1'b1, 1'b1, 1'b0);
        step("adv1", 64'h8,  2'd0, 1'b1, 1'b1, 1'b0);
        step("adv2", 64'hC,  2'd0, 1'b1, 1'b1, 1'b0);
        step("adv3", 64'h10, 2'd0, 1'b1, 1'b1, 1'b0);
        DE_FE_CF = 1'b1;
        step("cf_nt", 64'h14, 2'd1, 1'b0, 1'b0, 1'b0);
        idle();
        step("nt_wait0", 64'h14, 2'd1, 1'b0, 1'b0, 1'b0);
        step("nt_wait1", 64'h14, 2'd1, 1'b0, 1'b0, 1'b0);
        WB_FE_BR_STALL = 1'b1; WB_FE_Target_Address = 64'h40;
        step("br_not_taken", 64'h14, 2'd0, 1'b0, 1'b1, 1'b0);
        chk_cnt("br_not_taken", 32'd3);
        idle();
        step("nt_hold", 64'h14, 2'd0, 1'b0, 1'b1, 1'b0);

        // Misaligned redirect target
        ICACHE_R = 1'b1; DE_FE_CF = 1'b1;
        step("cf3", 64'h18, 2'd1, 1'b0, 1'b0, 1'b0);
        idle();
        WB_FE_BR_STALL = 1'b1; WB_FE_PC_MUX = 1'b1; WB_FE_Target_Address = 64'h42;
        step("iam_set", 64'h18, 2'd3, 1'b0, 1'b0, 1'b1);
        WB_FE_Target_Address = 64'h40;
        step("iam_hold", 64'h18, 2'd3, 1'b0, 1'b0, 1'b0);
        idle();
        TRAP_CS = 1'b1; TRAP_Target = 64'h100;
        step("iam_trap", 64'h100, 2'd0, 1'b0, 1'b1, 1'b0);

        // ECALL: SYSTEM entry, then release with trap
        idle();
        ICACHE_R = 1'b1; DE_FE_SYS = 1'b1;
        step("sys_enter", 64'h104, 2'd2, 1'b0, 1'b0, 1'b0);
        idle();
        step("trap_wait", 64'h104, 2'd2, 1'b0, 1'b0, 1'b0);
        WB_FE_TRAP_STALL = 1'b1; TRAP_CS = 1'b1; TRAP_Target = 64'h200;
        step("ecall", 64'h200, 2'd0, 1'b0, 1'b1, 1'b0);

        // CF and SYS together: SYS wins; release without trap keeps PC
        idle();
        ICACHE_R = 1'b1; DE_FE_CF = 1'b1; DE_FE_SYS = 1'b1;
        step("cf_sys", 64'h204, 2'd2, 1'b0, 1'b0, 1'b0);
        idle();
        WB_FE_TRAP_STALL = 1'b1;
        step("trap_nocs", 64'h204, 2'd0, 1'b0, 1'b1, 1'b0);

        // Interrupt while in BR_WAIT beats a same-cycle branch release
        idle();
        ICACHE_R = 1'b1; DE_FE_CF = 1'b1;
        step("cf4", 64'h208, 2'd1, 1'b0, 1'b0, 1'b0);
        idle();
        step("bw0", 64'h208, 2'd1, 1'b0, 1'b0, 1'b0);
        step("bw1", 64'h208, 2'd1, 1'b0, 1'b0, 1'b0);
        TRAP_CS = 1'b1; TRAP_Target = 64'h300;
        WB_FE_BR_STALL = 1'b1; WB_FE_PC_MUX = 1'b1; WB_FE_Target_Address = 64'h40;
        step("irq", 64'h300, 2'd0, 1'b0, 1'b1, 1'b0);
        chk_cnt("irq", 32'd12);

        // Decode stall holds PC but keeps FE_V
        idle();
        ICACHE_R = 1'b1; DE_STALL = 1'b1;
        step("de_stall", 64'h300, 2'd0, 1'b1, 1'b1, 1'b0);
        DE_STALL = 1'b0;
        step("de_release", 64'h304, 2'd0, 1'b1, 1'b1, 1'b0);

        // Same-cycle conflict in RUN: writeback redirect wins over decode CF
        DE_FE_CF = 1'b1; WB_FE_PC_MUX = 1'b1; WB_FE_BR_STALL = 1'b1;
        WB_FE_Target_Address = 64'h80;
        step("run_conflict", 64'h80, 2'd0, 1'b0, 1'b1, 1'b0);

        // 64-bit wrap of the sequential PC
        idle();
        TRAP_CS = 1'b1; TRAP_Target = 64'hFFFF_FFFF_FFFF_FFFC;
        step("wrap_load", 64'hFFFF_FFFF_FFFF_FFFC, 2'd0, 1'b0, 1'b1, 1'b0);
        idle();
        ICACHE_R = 1'b1;
        step("wrap", 64'h0, 2'd0, 1'b1, 1'b1, 1'b0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
